// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : PC, in-order instruction-memory requests, fetch queue to IF/ID.
// Revision : 1.0
// ============================================================================
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              inst_valid
);
    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_CNT_W-1:0] r_outst;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_q_head;
    logic [c_PTR_W-1:0] r_q_tail;
    logic [c_PTR_W-1:0] r_p_head;
    logic [c_PTR_W-1:0] r_p_tail;
    logic [ADDR_W-1:0]  r_q_pc   [DEPTH];
    logic [31:0]        r_q_inst [DEPTH];
    logic [ADDR_W-1:0]  r_p_pc   [DEPTH];

    logic               w_valid;
    logic               w_pop;
    logic               w_xfer;
    logic               w_resp;
    logic               w_keep;
    logic               w_discard;
    logic [c_CNT_W:0]   w_credit_used;
    logic               w_unused_jump_lsb;

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && !stall && !jump_valid;
    // The slot freed by this cycle's pop is reusable at once; this keeps one
    // instruction per cycle with a 1-cycle memory and DEPTH = 2.
    assign w_credit_used = {1'b0, r_outst} + {1'b0, r_count} - (c_CNT_W + 1)'(w_pop);
    assign imem_req  = !rst && !jump_valid && (w_credit_used < c_DEPTH);
    assign imem_addr = r_pc;
    assign w_xfer    = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp    = imem_rvalid && (r_outst != '0);
    assign w_keep    = w_resp && !jump_valid && (r_drop == '0);
    assign w_discard = w_resp && !jump_valid && (r_drop != '0);

    assign w_unused_jump_lsb = ^jump_target[1:0];

    assign inst       = w_valid ? r_q_inst[r_q_head] : 32'h0;
    assign pc_addr    = w_valid ? r_q_pc[r_q_head]   : '0;
    assign inst_valid = w_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_outst  <= '0;
            r_drop   <= '0;
            r_count  <= '0;
            r_q_head <= '0;
            r_q_tail <= '0;
            r_p_head <= '0;
            r_p_tail <= '0;
        end else begin
            if (w_xfer) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_p_tail <= r_p_tail + c_PTR_W'(1);
            end else if (jump_valid) begin
                r_pc <= {jump_target[ADDR_W-1:2], 2'b00};
            end

            if (w_resp) begin
                r_p_head <= r_p_head + c_PTR_W'(1);
            end

            r_outst <= r_outst + c_CNT_W'(w_xfer) - c_CNT_W'(w_resp);

            if (jump_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_drop   <= r_outst - c_CNT_W'(w_resp);
                r_count  <= '0;
                r_q_head <= '0;
                r_q_tail <= '0;
            end else begin
                if (w_discard) begin
                    r_drop <= r_drop - c_CNT_W'(1);
                end
                if (w_keep) begin
                    r_q_tail <= r_q_tail + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_q_head <= r_q_head + c_PTR_W'(1);
                end
                case ({w_keep, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_p_pc[r_p_tail] <= r_pc;
        end
        if (w_keep) begin
            r_q_pc[r_q_tail]   <= r_p_pc[r_p_head];
            r_q_inst[r_q_tail] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for inst_fetch: latency-programmable memory model, expected-PC scoreboard
// drained by a monitor, plus directed timing checks.
module tb_inst_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc_addr;
    logic        inst_valid;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_gnt = 0;
    int cyc = 0;
    int lat = 1;
    int gnt_off = 0;
    bit chk_credit = 1'b0;

    logic [31:0] exp_q [$];
    logic [31:0] m_addr [$];
    int          m_due [$];

    always #5 clk = ~clk;

    inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .jump_valid(jump_valid), .jump_target(jump_target), .stall(stall),
        .inst(inst), .pc_addr(pc_addr), .inst_valid(inst_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_range(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(a + 32'(4 * i));
    endtask

    // Memory: in-order responses, each 'lat' cycles after its grant.
    always @(negedge clk) begin
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (rst) begin
            m_addr.delete();
            m_due.delete();
            imem_gnt = 1'b0;
        end else begin
            if (m_addr.size() > 0 && m_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_addr[0]);
                void'(m_addr.pop_front());
                void'(m_due.pop_front());
            end
            imem_gnt = (gnt_off == 0);
            if (gnt_off > 0) gnt_off--;
            if (imem_req && imem_gnt) begin
                m_addr.push_back(imem_addr);
                m_due.push_back(cyc + lat);
                n_gnt++;
            end
        end
    end

    // Monitor: consumed instructions against the scoreboard, stall stability, credits.
    logic        p_stall = 1'b0, p_valid = 1'b0, p_jump = 1'b0;
    logic [31:0] p_pc = 32'h0, p_inst = 32'h0;
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (rst) begin
            p_stall = 1'b0;
            p_valid = 1'b0;
            p_jump  = 1'b0;
        end else begin
            if (p_stall && p_valid && !p_jump) begin
                chk("stall_hold_pc", pc_addr, p_pc);
                chk("stall_hold_inst", inst, p_inst);
                chk("stall_hold_valid", inst_valid, 1);
            end
            if (chk_credit && stall)
                chk("credit_le_depth", 32'(n_gnt - n_pop <= DEPTH), 1);
            if (inst_valid && !stall && !jump_valid) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_inst: got pc %h, none expected", pc_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", pc_addr, e);
                    chk("sb_inst", inst, mem_word(e));
                end
            end
            p_stall = stall;
            p_valid = inst_valid;
            p_pc    = pc_addr;
            p_inst  = inst;
            p_jump  = jump_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  seen;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc_addr", pc_addr, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Reset release, stall 5 cycles on the first instruction.
        push_range(32'h0, 64);
        @(negedge clk); rst = 1'b0; #2;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        @(negedge clk); #2;
        chk("valid_c1", inst_valid, 0);
        @(negedge clk); stall = 1'b1; chk_credit = 1'b1; #2;
        chk("valid_c2", inst_valid, 1);
        chk("pc_c2", pc_addr, 32'h0);
        repeat (4) @(negedge clk);
        @(negedge clk); stall = 1'b0; chk_credit = 1'b0; #2;
        chk("resume_pc0", pc_addr, 32'h0);
        @(negedge clk); #2;
        chk("resume_pc4", pc_addr, 32'h4);
        @(negedge clk); #2;
        chk("resume_pc8", pc_addr, 32'h8);
        repeat (6) @(negedge clk);
        #2 chk("progress_p1", 32'(n_pop >= 8), 1);

        // Redirect in 1-cycle steady state, unaligned target.
        @(negedge clk);
        jump_valid = 1'b1; jump_target = 32'h203;
        exp_q.delete(); push_range(32'h200, 32);
        #2 chk("jump_no_req", imem_req, 0);
        @(negedge clk); jump_valid = 1'b0; #2;
        chk("jump_n1_valid", inst_valid, 0);
        chk("jump_n1_req", imem_req, 1);
        chk("jump_n1_addr", imem_addr, 32'h200);
        @(negedge clk); #2;
        chk("jump_n2_valid", inst_valid, 0);
        @(negedge clk); #2;
        chk("jump_n3_valid", inst_valid, 1);
        chk("jump_n3_pc", pc_addr, 32'h200);
        repeat (8) @(negedge clk);

        // Redirect with two requests in flight (3-cycle memory).
        @(negedge clk); lat = 3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #2;
            if (m_addr.size() == 2) seen = 1'b1;
        end
        chk("two_in_flight_reached", 32'(seen), 1);
        @(negedge clk);
        jump_valid = 1'b1; jump_target = 32'h100;
        exp_q.delete(); push_range(32'h100, 32);
        base = n_pop;
        @(negedge clk); jump_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #2;
            if (imem_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("jump2_req_seen", 32'(seen), 1);
        chk("jump2_addr", imem_addr, 32'h100);
        repeat (15) @(negedge clk);
        #2 chk("progress_p3", 32'(n_pop - base >= 3), 1);

        // Grant withheld 3 cycles after a redirect, 3-cycle latency.
        @(negedge clk); stall = 1'b1;
        repeat (12) @(negedge clk);
        stall = 1'b0; jump_valid = 1'b1; jump_target = 32'h300; gnt_off = 4;
        exp_q.delete(); push_range(32'h300, 32);
        base = n_pop;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); jump_valid = 1'b0; #2;
            chk("gnt_wait_req", imem_req, 1);
            chk("gnt_wait_addr", imem_addr, 32'h300);
        end
        repeat (20) @(negedge clk);
        #2 chk("progress_p4", 32'(n_pop - base >= 3), 1);

        // PC wrap at the top of the address space.
        @(negedge clk); lat = 1;
        repeat (10) @(negedge clk);
        jump_valid = 1'b1; jump_target = 32'hFFFF_FFF8;
        exp_q.delete(); push_range(32'hFFFF_FFF8, 32);
        @(negedge clk); jump_valid = 1'b0; #2;
        chk("wrap_addr_f8", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk); #2;
        chk("wrap_addr_fc", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #2;
        chk("wrap_addr_0", imem_addr, 32'h0);
        chk("wrap_req_0", imem_req, 1);
        chk("wrap_pc_f8", pc_addr, 32'hFFFF_FFF8);
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_pc_addr", pc_addr, 32'h0);
        chk("arst_req", imem_req, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_range(32'h0, 16);
        base = n_pop;
        @(negedge clk); rst = 1'b0; #2;
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk); #2;
        chk("restart_valid_c2", inst_valid, 1);
        chk("restart_pc_c2", pc_addr, 32'h0);
        repeat (6) @(negedge clk);
        #2 chk("progress_p6", 32'(n_pop - base >= 5), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
